// File: rtl/bk_arb_pkg.sv
// Shared types and helpers for the Brent-Kung adder arbiter.
// Operand width is fixed by the adder instance.
package bk_arb_pkg;

    localparam int BK_OP_W  = 12;
    localparam int BK_SUM_W = 13;
    localparam int BK_CNT_W = 16;

    typedef logic [BK_OP_W-1:0]  bk_op_t;
    typedef logic [BK_SUM_W-1:0] bk_sum_t;

    // The adder expects A and B bit pairs interleaved: {.., B1, A1, B0, A0}.
    function automatic logic [2*BK_OP_W-1:0] bk_interleave(input bk_op_t a, input bk_op_t b);
        logic [2*BK_OP_W-1:0] r;
        r = '0;
        for (int k = 0; k < BK_OP_W; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_adder_arbiter_if.sv
// Request/response bundle between client datapaths and the shared adder.
// master = clients and consumer, slave = bk_adder_arbiter.
interface bk_adder_arbiter_if
    import bk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*BK_OP_W-1:0] req_a;
    logic [NUM_REQ*BK_OP_W-1:0] req_b;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    bk_sum_t                    rsp_sum;
    logic                       busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );

endinterface

// File: rtl/BrentKung.sv
// 12-bit Brent-Kung parallel-prefix adder, no carry-in.
// Inputs are interleaved: INPUTS[2k]=A[k], INPUTS[2k+1]=B[k].
module BrentKung (
    input  logic [23:0] INPUTS,
    output logic [12:0] OUTS
);

    logic [11:0] a_bits;
    logic [11:0] b_bits;
    logic [11:0] p0;
    logic [11:0] gg;
    logic [11:0] pp;

    always_comb begin
        a_bits = '0;
        b_bits = '0;
        for (int k = 0; k < 12; k++) begin
            a_bits[k] = INPUTS[2*k];
            b_bits[k] = INPUTS[2*k+1];
        end
        p0 = a_bits ^ b_bits;
    end

    // Up-sweep builds power-of-two groups, down-sweep fills in the remaining prefixes.
    always_comb begin
        gg = a_bits & b_bits;
        pp = p0;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 12; i++) begin
                if ((((i + 1) % (2 << l)) == 0) && (i >= (1 << l))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 12; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (3 << l) - 1)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
    end

    always_comb begin
        OUTS[0]  = p0[0];
        OUTS[12] = gg[11];
        for (int i = 1; i < 12; i++) begin
            OUTS[i] = p0[i] ^ gg[i-1];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps upward.
// Reusable for any shared resource; enable gates the grant outputs.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int   pos;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found     = 1'b1;
                grant_idx = pos[IDX_W-1:0];
            end
        end
        any_grant = found & enable;
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Shares one Brent-Kung adder among NUM_REQ requesters with a 1-entry result register.
// Optional per-requester grant counters: define BK_ARB_PERF_EN.
module bk_adder_arbiter
    import bk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    bk_adder_arbiter_if.slave           bus
`ifdef BK_ARB_PERF_EN
    ,
    input  logic                        clr_cnt,
    output logic [NUM_REQ*BK_CNT_W-1:0] grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int OP_W = BK_OP_W;

    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    bk_sum_t              rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 slot_free;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 any_grant;
    bk_op_t               sel_a;
    bk_op_t               sel_b;
    logic [2*OP_W-1:0]    adder_in;
    bk_sum_t              adder_out;

    // Reset is folded in so no requester sees ready while rst is held.
    assign slot_free = (~rsp_valid_q | bus.rsp_ready) & ~rst;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .enable    (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_a    = bus.req_a[grant_idx*OP_W +: OP_W];
        sel_b    = bus.req_b[grant_idx*OP_W +: OP_W];
        adder_in = bk_interleave(sel_a, sel_b);
    end

    BrentKung u_adder (
        .INPUTS (adder_in),
        .OUTS   (adder_out)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        ptr_d       = ptr_q;
        if (any_grant) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_sum_d   = adder_out;
            ptr_d       = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.busy      = rsp_valid_q | (|bus.req_valid);

`ifdef BK_ARB_PERF_EN
    logic [NUM_REQ-1:0][BK_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (any_grant && (cnt_q[grant_idx] != {BK_CNT_W{1'b1}})) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Directed bench for bk_adder_arbiter; covers perf counters when BK_ARB_PERF_EN is defined.
module tb_bk_adder_arbiter;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    bk_adder_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef BK_ARB_PERF_EN
    logic        clr_cnt;
    logic [63:0] grant_cnt;
`endif

    bk_adder_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef BK_ARB_PERF_EN
        ,
        .clr_cnt   (clr_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic setOperands(input int i, input logic [11:0] a, input logic [11:0] b);
        bus.req_a[i*12 +: 12] = a;
        bus.req_b[i*12 +: 12] = b;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic rspReady);
        bus.req_valid = valid;
        bus.rsp_ready = rspReady;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic [1:0] id, input logic [12:0] sum);
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
        checkOutput({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
        checkOutput({tag, "_sum"}, 32'(bus.rsp_sum), 32'(sum));
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    logic [1:0]  rrIds  [6];
    logic [12:0] rrSums [6];

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
`ifdef BK_ARB_PERF_EN
        clr_cnt = 1'b0;
`endif
        rrIds  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rrSums = '{13'h011, 13'h022, 13'h033, 13'h044, 13'h011, 13'h022};

        @(negedge clk);
        doReset();
        checkRsp("reset", 1'b0, 2'd0, 13'h0);
        checkOutput("reset_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);

        // Single request from requester 2
        setOperands(2, 12'h123, 12'h456);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_ready", 32'(bus.req_ready), 32'h4);
        checkOutput("single_busy", 32'(bus.busy), 32'h1);
        step();
        checkRsp("single", 1'b1, 2'd2, 13'h0579);

        // Pointer now 3: requester 3 beats requester 0
        setOperands(0, 12'hFFF, 12'h001);
        setOperands(3, 12'hFFF, 12'hFFF);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("ptr3_ready", 32'(bus.req_ready), 32'h8);
        step();
        checkRsp("carry_fff_fff", 1'b1, 2'd3, 13'h1FFE);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("wrap_ready", 32'(bus.req_ready), 32'h1);
        step();
        checkRsp("carry_fff_001", 1'b1, 2'd0, 13'h1000);
        applyStimulus(4'b0000, 1'b1);
        step();
        checkRsp("drain", 1'b0, 2'd0, 13'h1000);

        // Round robin, all valid, no bubbles
        doReset();
        for (int i = 0; i < 4; i++) begin
            setOperands(i, 12'(32'h010 * (i + 1)), 12'(i + 1));
        end
        applyStimulus(4'b1111, 1'b1);
        for (int n = 0; n < 6; n++) begin
            step();
            checkRsp($sformatf("rr%0d", n), 1'b1, rrIds[n], rrSums[n]);
        end

        // Backpressure: held result id1 sum 0x022, requester 1 re-presents
        setOperands(1, 12'h700, 12'h0AB);
        applyStimulus(4'b0010, 1'b0);
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("bp%0d_ready", n), 32'(bus.req_ready), 32'h0);
            checkRsp($sformatf("bp%0d", n), 1'b1, 2'd1, 13'h022);
            step();
        end
        checkOutput("bp_busy", 32'(bus.busy), 32'h1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("bp_release_ready", 32'(bus.req_ready), 32'h2);
        step();
        checkRsp("bp_reload", 1'b1, 2'd1, 13'h07AB);
        applyStimulus(4'b0000, 1'b1);
        step();
        checkOutput("bp_drained", 32'(bus.rsp_valid), 32'h0);

        // Asynchronous reset while holding a result
        setOperands(0, 12'h005, 12'h003);
        applyStimulus(4'b0001, 1'b0);
        step();
        checkRsp("pre_rst", 1'b1, 2'd0, 13'h008);
        applyStimulus(4'b1001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkRsp("async_rst", 1'b0, 2'd0, 13'h0);
        checkOutput("async_rst_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1001, 1'b1);
        checkOutput("post_rst_ready", 32'(bus.req_ready), 32'h1);
        step();
        checkRsp("post_rst", 1'b1, 2'd0, 13'h008);
        applyStimulus(4'b0000, 1'b1);
        step();

`ifdef BK_ARB_PERF_EN
        doReset();
        applyStimulus(4'b0010, 1'b1);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checkOutput("cnt1_sat", 32'(grant_cnt[16 +: 16]), 32'hFFFF);
        checkOutput("cnt0_zero", 32'(grant_cnt[0 +: 16]), 32'h0);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        #1;
        checkOutput("cnt1_clr", 32'(grant_cnt[16 +: 16]), 32'h0);
        step();
        checkOutput("cnt1_after_clr", 32'(grant_cnt[16 +: 16]), 32'h1);
        applyStimulus(4'b0000, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bk_adder_arbiter.md
Name: bk_adder_arbiter

Overview:
- Shares one combinational 12-bit Brent-Kung adder among NUM_REQ requesters.
- Each requester uses a valid/ready request channel. Results return on one shared response channel, tagged with the requester ID.
- A round-robin grant stage feeds a single-entry registered result stage. Adder-use latency is 1 cycle.
- Sits between the client datapaths and the existing BrentKung adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester tag (localparam, derived).
- OP_W, 12, operand width (localparam, fixed by the adder; must not be overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*OP_W  operand A; requester i uses slice [i*12 +: 12].
- req_b  in  NUM_REQ*OP_W  operand B; same slicing as req_a.
- rsp_valid  out  1  result register holds a valid sum.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that produced rsp_sum.
- rsp_sum  out  OP_W+1  sum of A and B; bit 12 is carry-out.
- busy  out  1  rsp_valid OR any req_valid.

Behaviour:
- Reset (asynchronous, active-high). Effects:
  - rsp_valid=0, rsp_id=0, rsp_sum=0.
  - Priority pointer ptr=0; req_ready=0.
  - Reset mid-transaction drops any held result silently.
  - Requesters re-present after reset.
- Accept condition: slot_free = ~rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Search starts at ptr and moves upward with wrap-around.
  - The first requester with req_valid=1 is granted.
  - req_ready[g] = slot_free & (g is the granted index). All other ready bits are 0.
- Transfer: a transfer on requester g occurs when req_valid[g] & req_ready[g].
- Adder connection:
  - Adder input bit pairs are interleaved: adder INPUTS[2k]=A[k], INPUTS[2k+1]=B[k], for k=0..11.
  - OUTS[12:0] carries sum[12:0]. There is no carry-in.
- On transfer, at the next clock edge:
  - rsp_sum <= adder output; rsp_id <= g; rsp_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
- Without a transfer:
  - rsp_ready & rsp_valid clears rsp_valid; rsp_sum/rsp_id hold their last values.
  - No grant leaves ptr unchanged.
- Simultaneous drain and new transfer in the same cycle: the new result is loaded with rsp_valid staying 1. This gives back-to-back throughput of 1 per cycle.
- Latency: request accepted in cycle t → rsp_valid in cycle t+1.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, all req_ready=0.
  - rsp_sum and rsp_id stay stable until accepted.
- Requester obligations:
  - Hold req_valid/req_a/req_b stable until accepted.
  - The arbiter may move the grant to another requester while rsp is stalled. The pointer only advances on an actual transfer.
- Arithmetic: unsigned. 0xFFF+0x001 = 0x1000.
- Starvation bound: a continuously valid requester is granted within NUM_REQ transfers.

Optional Feature:
- Macro: BK_ARB_PERF_EN.
- Defined:
  - Adds output port grant_cnt, width NUM_REQ*16: one 16-bit saturating counter per requester.
  - Counter i increments on each transfer from requester i and saturates at 0xFFFF.
  - Adds input clr_cnt: synchronous clear, which takes priority over increment.
  - Counters reset to 0 on rst.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bk_arb_pkg:
  - localparam BK_OP_W=12, BK_SUM_W=13, BK_CNT_W=16.
  - typedef bk_op_t (logic [11:0]) and bk_sum_t (logic [12:0]).
  - Function bk_interleave(a,b) returning the 24-bit adder input vector.
- Sub-module rr_arbiter:
  - Parameter N. Inputs: req vector, ptr, enable. Outputs: one-hot grant, encoded grant index, any_grant.
  - Purely combinational, so it can be reused by other shared-resource blocks.
- The adder is the existing BrentKung block, instantiated once.

Test Plan:
- Single request: reset, then req_valid[2]=1 with A=0x123, B=0x456, rsp_ready=1 → req_ready[2]=1 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x0579; ptr=3.
- Carry-out: A=0xFFF, B=0x001 → rsp_sum=0x1000. Then A=0xFFF, B=0xFFF → 0x1FFE.
- Round-robin with all 4 requesters continuously valid and rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 5 cycles → all req_ready=0 and rsp_sum/rsp_id stable. Raise rsp_ready with req_valid[1] pending → drain and new load in the same cycle; rsp_valid stays 1 and rsp_id=1.
- Reset mid-operation: assert rst asynchronously between edges while rsp_valid=1 → rsp_valid, rsp_sum and req_ready go to 0 immediately; after release, ptr=0 and requester 0 wins over requester 3.
- Perf counters (BK_ARB_PERF_EN defined): 70000 grants to requester 1 → grant_cnt[16+:16]=0xFFFF. Pulse clr_cnt → 0 next cycle.
